// File: rtl/btn_conditioner_pkg.sv
// Shared helpers for the push-button front end.
package btn_conditioner_pkg;

    // Width that can hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, debounce, edge pulses, long-press pulse.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = cnt_w(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [DW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_fired;
    logic          r_press;
    logic          r_release;
    logic          r_long;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_stable  <= r_sync2;
                r_cnt     <= '0;
                r_press   <= r_sync2;
                r_release <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Hold timer saturates once fired so a long press reports only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= '0;
            r_fired <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_stable) begin
                r_hold  <= '0;
                r_fired <= 1'b0;
            end else if (!r_fired) begin
                if (r_hold == HOLD_LAST) begin
                    r_long  <= 1'b1;
                    r_fired <= 1'b1;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end
    end

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: NUM_BTN independent debounce channels.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_btn    (btn[g]),
            .o_level  (btn_level[g]),
            .o_press  (btn_press[g]),
            .o_release(btn_release[g]),
            .o_long   (btn_long[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;

    int n_tests = 0;
    int n_fail  = 0;

    btn_conditioner #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .btn_level  (lvl),
        .btn_press  (prs),
        .btn_release(rel),
        .btn_long   (lng)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   np;
        int   pe;
        int   le;
        int   re;
        int   nl;
        logic ev;
        logic [3:0] seq;

        // Reset with all buttons held
        rst = 1'b1;
        btn = 4'hf;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outs", 32'({lvl, prs, rel, lng}), 32'h0);
        end
        rst = 1'b0;
        np = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            np += int'(prs != 4'h0);
        end
        check("rst_early_press", 32'(np), 32'd0);
        step();
        check("rst_press_e6", 32'(prs), 32'hf);
        rst = 1'b1;
        btn = 4'h0;
        step();
        step();
        rst = 1'b0;
        check("rst_clear", 32'({lvl, prs, rel, lng}), 32'h0);

        // Clean press on channel 0
        btn = 4'b0001;
        np = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            np += int'(lvl != 4'h0 || prs != 4'h0);
        end
        check("clean_early", 32'(np), 32'd0);
        step();
        check("clean_lvl_e6", 32'(lvl), 32'h1);
        check("clean_prs_e6", 32'(prs), 32'h1);
        step();
        check("clean_prs_e7", 32'(prs), 32'h0);
        check("clean_lvl_e7", 32'(lvl), 32'h1);
        btn = 4'b0000;
        np = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            np += int'(rel != 4'h0);
        end
        check("clean_rel_early", 32'(np), 32'd0);
        step();
        check("clean_rel_e6", 32'(rel), 32'h1);
        check("clean_lvl_off", 32'(lvl), 32'h0);
        step();
        check("clean_rel_e7", 32'(rel), 32'h0);

        // Bounce on channel 1
        seq = 4'b0101;
        np = 0;
        for (int i = 0; i < 4; i++) begin
            btn[1] = seq[i];
            step();
            np += int'(prs[1]);
        end
        btn[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            np += int'(prs[1]);
            if (k == 5) check("bounce_lvl_e5", 32'(lvl[1]), 32'h0);
            if (k == 6) check("bounce_lvl_e6", 32'(lvl[1]), 32'h1);
        end
        check("bounce_npress", 32'(np), 32'd1);
        btn[1] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check("bounce_lvl_off", 32'(lvl), 32'h0);

        // Short glitch on channel 2
        ev = 1'b0;
        btn[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            ev |= lvl[2] | prs[2] | rel[2];
        end
        btn[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            ev |= lvl[2] | prs[2] | rel[2];
        end
        check("glitch_none", 32'(ev), 32'h0);

        // Long press on channel 3
        pe = -1;
        le = -1;
        re = -1;
        nl = 0;
        btn[3] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 41) btn[3] = 1'b0;
            step();
            if (prs[3]) pe = k;
            if (lng[3]) begin
                le = k;
                nl++;
            end
            if (rel[3]) re = k;
        end
        check("long_press_e6", 32'(pe), 32'd6);
        check("long_delay", 32'(le - pe), 32'd20);
        check("long_once", 32'(nl), 32'd1);
        check("long_rel_e46", 32'(re), 32'd46);

        // Simultaneous press, then reset mid-hold
        btn = 4'b0011;
        for (int k = 0; k < 5; k++) step();
        step();
        check("simul_press", 32'(prs), 32'h3);
        nl = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            nl += int'(lng != 4'h0);
        end
        check("simul_prelong", 32'(nl), 32'd0);
        rst = 1'b1;
        step();
        check("midhold_rst", 32'({lvl, prs, rel, lng}), 32'h0);
        rst = 1'b0;
        pe = -1;
        nl = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (prs == 4'b0011 && pe < 0) pe = k;
            if (k < 26) nl += int'(lng != 4'h0);
            if (k == 26) check("refresh_long", 32'(lng), 32'h3);
        end
        check("refresh_press", 32'(pe), 32'd6);
        check("refresh_nolong", 32'(nl), 32'd0);
        btn = 4'h0;
        for (int k = 0; k < 8; k++) step();
        check("final_idle", 32'(lvl), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side front end for the button-driven LED blocks: takes raw asynchronous push-button levels and produces clean, synchronous events for downstream toggle/LED logic.
- Each channel is synchronized, debounced and edge-detected; each channel also reports a long-press event.
- Sits between the board btn pins and any consumer (LED toggler, anode/LED drivers), so consumers never see bounce or metastability.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a level change. 10 ms at 50 MHz; must be >= 1.
- LONG_CYCLES, 50000000, cycles the debounced level must stay high before btn_long fires. 1 s at 50 MHz; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  NUM_BTN  raw asynchronous button levels; 1 = pressed.
- btn_level  output  NUM_BTN  debounced level per channel.
- btn_press  output  NUM_BTN  one-cycle pulse on debounced 0->1.
- btn_release  output  NUM_BTN  one-cycle pulse on debounced 1->0.
- btn_long  output  NUM_BTN  one-cycle pulse when the level has been high for LONG_CYCLES; at most once per press.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, sampled on the clk rising edge.
  - While rst=1 at an edge, clear all state: sync FFs, stable level, debounce counter, hold counter, long-fired flag.
  - All outputs are 0 after that edge. Reset mid-bounce or mid-hold discards all progress.
- Synchronizer: two-FF chain per channel (sync1 <= btn, sync2 <= sync1). Only sync2 feeds downstream logic.
- Debounce, per channel:
  - Counter width = $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == stable: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Result: a mismatch must persist for DEBOUNCE_CYCLES consecutive cycles. Any single-cycle return to the stable value restarts the count.
- Latency: a btn change meeting setup before edge 1 reaches sync2 at edge 2. btn_level changes at edge 2+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=4, that is edge 6.
- Edge outputs:
  - All outputs are registered.
  - btn_press and btn_release assert on the same edge that btn_level changes, and deassert on the next edge.
  - press and release can never be high together on one channel.
- Long press:
  - The hold counter runs only while stable=1 and the long-fired flag is 0. It increments every cycle; width = $clog2(LONG_CYCLES+1).
  - When hold == LONG_CYCLES-1: btn_long pulses for one cycle, the long-fired flag is set, and the counter stops (saturates, no wrap).
  - When stable=0: hold counter and long-fired flag are cleared.
  - btn_long is asserted exactly LONG_CYCLES cycles after the btn_press edge.
  - A release before that point produces no btn_long.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- No combinational path from btn to any output.

Decomposition:
- Shared package: none needed beyond a localparam width helper; widths are derived inside the module.
- One sub-module: btn_debounce_ch, covering a single channel (sync, debounce counter, edge detect, long-press), with parameters DEBOUNCE_CYCLES and LONG_CYCLES.
- btn_conditioner instantiates NUM_BTN copies via a generate loop and concatenates the outputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20, with 20 ns clk.
- Reset: hold rst=1 for 3 edges with btn=4'b1111 -> all outputs 0 during reset; no press pulse earlier than 6 edges after rst falls.
- Clean press: btn[0] 0->1 before edge 1, then held -> btn_level[0]=1 and btn_press[0]=1 at edge 6; btn_press[0]=0 at edge 7; other channels stay 0.
- Bounce: btn[1] toggles 1,0,1,0 on consecutive cycles, then held 1 -> exactly one btn_press[1]; btn_level[1] rises 6 edges after the final 0->1.
- Short glitch: btn[2] high for 3 cycles only -> btn_level[2] never rises; no press or release.
- Long press: btn[3] held 40 cycles, then released -> btn_long[3] pulses once, 20 cycles after btn_press[3]; btn_release[3] occurs 6 edges after release; no second btn_long.
- Simultaneous events and reset mid-hold:
  - btn[0] and btn[1] pressed on the same cycle -> press pulses on the same edge.
  - rst asserted 10 cycles after btn_press[0] -> btn_level clears; no btn_long; after rst releases with btn still held, a fresh press is detected 6 edges later.
